// File: rtl/mips_cpu_store_unit.sv
// mips_cpu_store_unit: turns a MIPS store into a word-aligned Avalon write with byte enables.
module mips_cpu_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] address_o,
  output logic        write_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  input  logic        waitrequest_i,
  output logic        done_o,
  output logic        fault_o
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, lane_wd;
  logic [3:0] be_q, be_d, lane_be;
  logic done_q, done_d, fault_q, fault_d, bad;
  logic [1:0] off;
  logic [4:0] sh;
  assign off = addr_i[1:0];
  assign sh = {off, 3'b000};
  // Little-endian lanes: byte offset k lands on lane k, same as the load path.
  always_comb begin
    lane_be = 4'b0000;
    lane_wd = 32'h0;
    bad = 1'b1;
    case (opcode_i)
      6'b101000: begin
        lane_be = 4'b0001 << off;
        lane_wd = {24'h0, rt_data_i[7:0]} << sh;
        bad = 1'b0;
      end
      6'b101001: begin
        lane_be = off[1] ? 4'b1100 : 4'b0011;
        lane_wd = off[1] ? {rt_data_i[15:0], 16'h0} : {16'h0, rt_data_i[15:0]};
        bad = off[0];
      end
      6'b101011: begin
        lane_be = 4'b1111;
        lane_wd = rt_data_i;
        bad = off != 2'b00;
      end
      6'b101010: begin
        lane_be = 4'b1111 >> (2'd3 - off);
        lane_wd = rt_data_i >> (5'd24 - sh);
        bad = 1'b0;
      end
      6'b101110: begin
        lane_be = 4'b1111 << off;
        lane_wd = rt_data_i << sh;
        bad = 1'b0;
      end
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    be_d = be_q;
    wd_d = wd_q;
    done_d = 1'b0;
    fault_d = 1'b0;
    if (state_q == IDLE && req_valid_i) begin
      fault_d = bad;
      state_d = bad ? IDLE : WRITE;
      addr_d = bad ? addr_q : {addr_i[31:2], 2'b00};
      be_d = bad ? be_q : lane_be;
      wd_d = bad ? wd_q : lane_wd;
    end else if (state_q == WRITE && !waitrequest_i) begin
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= 32'h0;
      be_q <= 4'h0;
      wd_q <= 32'h0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      done_q <= done_d;
      fault_q <= fault_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign write_o = state_q == WRITE;
  assign address_o = addr_q;
  assign byteenable_o = be_q;
  assign writedata_o = wd_q;
  assign done_o = done_q;
  assign fault_o = fault_q;
endmodule

// File: tb/tb_mips_cpu_store_unit.sv
// tb_mips_cpu_store_unit: scoreboard bench; expected bus writes and faults are queued at request time.
module tb_mips_cpu_store_unit;
  logic clk = 0, rst_n = 0, req_valid = 0, waitrequest = 0;
  logic [5:0] opcode = 0;
  logic [31:0] addr = 0, rt_data = 0;
  logic req_ready, write, done, fault;
  logic [31:0] address, writedata;
  logic [3:0] byteenable;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] wd; bit flt;} exp_t;
  exp_t q[$];
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SWL = 6'b101010, SW = 6'b101011, SWR = 6'b101110;
  always #5 clk = ~clk;
  mips_cpu_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .opcode_i(opcode), .addr_i(addr), .rt_data_i(rt_data), .address_o(address),
    .write_o(write), .byteenable_o(byteenable), .writedata_o(writedata),
    .waitrequest_i(waitrequest), .done_o(done), .fault_o(fault));
  // Scoreboard side: pops one expectation per accepted bus write or fault pulse.
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (done && fault) begin
      tests++; fails++; $display("FAIL done_fault_overlap: both high");
    end
    if ((write && !waitrequest) || fault) begin
      tests++;
      if (q.size() == 0) begin
        fails++; $display("FAIL sb_unexpected: write=%b fault=%b with empty queue", write, fault);
      end else begin
        e = q.pop_front();
        if (fault !== e.flt || (!e.flt && (address !== e.a || byteenable !== e.be || writedata !== e.wd))) begin
          fails++;
          $display("FAIL sb_txn: got fault=%b a=%h be=%b wd=%h, want fault=%b a=%h be=%b wd=%h",
                   fault, address, byteenable, writedata, e.flt, e.a, e.be, e.wd);
        end
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic [3:0] be, input logic [31:0] wd, input bit flt);
    @(posedge clk); #1;
    req_valid = 1; opcode = op; addr = a; rt_data = rt;
    q.push_back('{a: {a[31:2], 2'b00}, be: be, wd: wd, flt: flt});
  endtask
  task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic [3:0] be, input logic [31:0] wd, input bit flt);
    drive(op, a, rt, be, wd, flt);
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk); tests++;
    if (write !== !flt || fault !== flt || req_ready !== flt) begin
      fails++; $display("FAIL first_cycle op=%b a=%h: write=%b fault=%b ready=%b, want write=%b fault=%b ready=%b",
                        op, a, write, fault, req_ready, !flt, flt, flt);
    end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (write !== 0 || done !== !flt || fault !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL second_cycle op=%b a=%h: write=%b done=%b fault=%b ready=%b, want 0 %b 0 1",
                        op, a, write, done, fault, req_ready, !flt);
    end
  endtask
  task automatic test_reset;
    req_valid = 1; opcode = SW; addr = 32'h40; rt_data = 32'h5;
    repeat (2) @(posedge clk);
    #1; tests++;
    if (write !== 0 || address !== 0 || byteenable !== 0 || writedata !== 0 || done !== 0 || fault !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL reset_state: write=%b a=%h be=%b wd=%h done=%b fault=%b ready=%b",
                        write, address, byteenable, writedata, done, fault, req_ready);
    end
    req_valid = 0;
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_basic;
    store(SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
    store(SB, 32'h203, 32'h000000A5, 4'b1000, 32'hA5000000, 0);
    store(SB, 32'h201, 32'hFFFFFF5A, 4'b0010, 32'h00005A00, 0);
    store(SH, 32'h202, 32'h00001234, 4'b1100, 32'h12340000, 0);
    store(SH, 32'h200, 32'hABCD5678, 4'b0011, 32'h00005678, 0);
  endtask
  task automatic test_partial;
    logic [3:0] lbe [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [31:0] lwd [8] = '{32'h00000011, 32'h00001122, 32'h00112233, 32'h11223344,
                             32'h11223344, 32'h22334400, 32'h33440000, 32'h44000000};
    for (int i = 0; i < 8; i++)
      store(i < 4 ? SWL : SWR, 32'h400 + 32'(i % 4), 32'h11223344, lbe[i], lwd[i], 0);
  endtask
  task automatic test_fault;
    store(SW, 32'h102, 32'h1, 4'h0, 32'h0, 1);
    store(SH, 32'h101, 32'h2, 4'h0, 32'h0, 1);
    store(6'b100011, 32'h100, 32'h3, 4'h0, 32'h0, 1);
    tests++;
    if (address !== 32'h400 || byteenable !== 4'b1000 || writedata !== 32'h44000000) begin
      fails++; $display("FAIL fault_holds_bus: a=%h be=%b wd=%h, want 00000400 1000 44000000", address, byteenable, writedata);
    end
  endtask
  task automatic test_wait;
    waitrequest = 1;
    drive(SW, 32'h500, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 0);
    @(posedge clk); #1;
    opcode = SB; addr = 32'h777; rt_data = 32'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tests++;
      if (write !== 1 || req_ready !== 0 || done !== 0 || address !== 32'h500 || byteenable !== 4'b1111 || writedata !== 32'h0BADF00D) begin
        fails++; $display("FAIL wait_stable[%0d]: write=%b ready=%b done=%b a=%h be=%b wd=%h", i, write, req_ready, done, address, byteenable, writedata);
      end
      @(posedge clk); #1;
    end
    waitrequest = 0; req_valid = 0;
    @(negedge clk); tests++;
    if (write !== 1 || done !== 0 || address !== 32'h500) begin
      fails++; $display("FAIL wait_release: write=%b done=%b a=%h, want 1 0 00000500", write, done, address);
    end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (done !== 1 || write !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL wait_done: done=%b write=%b ready=%b, want 1 0 1", done, write, req_ready);
    end
  endtask
  task automatic test_back_to_back;
    drive(SW, 32'h600, 32'hAAAA5555, 4'b1111, 32'hAAAA5555, 0);
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    drive_now(SB, 32'h601, 32'h0000007E, 4'b0010, 32'h00007E00);
    @(negedge clk); tests++;
    if (done !== 1 || req_ready !== 1 || write !== 0) begin
      fails++; $display("FAIL b2b_gap: done=%b ready=%b write=%b, want 1 1 0", done, req_ready, write);
    end
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk); tests++;
    if (write !== 1 || done !== 0) begin
      fails++; $display("FAIL b2b_second: write=%b done=%b, want 1 0", write, done);
    end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (done !== 1 || write !== 0) begin
      fails++; $display("FAIL b2b_done: done=%b write=%b, want 1 0", done, write);
    end
  endtask
  task automatic drive_now(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                           input logic [3:0] be, input logic [31:0] wd);
    req_valid = 1; opcode = op; addr = a; rt_data = rt;
    q.push_back('{a: {a[31:2], 2'b00}, be: be, wd: wd, flt: 0});
  endtask
  task automatic test_reset_in_write;
    waitrequest = 1;
    drive(SW, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk); tests++;
    if (write !== 1) begin
      fails++; $display("FAIL rst_pre: write=%b, want 1", write);
    end
    #1 rst_n = 0;
    #1 tests++;
    if (write !== 0 || address !== 0 || byteenable !== 0 || writedata !== 0 || done !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL rst_async: write=%b a=%h be=%b wd=%h done=%b ready=%b", write, address, byteenable, writedata, done, req_ready);
    end
    void'(q.pop_back());
    @(posedge clk); #1; rst_n = 1; waitrequest = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); tests++;
      if (done !== 0 || write !== 0) begin
        fails++; $display("FAIL rst_no_done[%0d]: done=%b write=%b, want 0 0", i, done, write);
      end
    end
    store(SW, 32'h304, 32'h13579BDF, 4'b1111, 32'h13579BDF, 0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_fault;
    test_wait;
    test_back_to_back;
    test_reset_in_write;
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
